// File: rtl/io_port_unit.sv
// I/O port stage behind the control unit: OUT writes queue in a small TX FIFO
// drained over valid/ready, and a single RX holding byte is returned on IN reads.
module io_port_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_enable,
    input  logic                     io_write_enable,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        port_out_data,
    output logic                     port_out_valid,
    input  logic                     port_out_ready,
    input  logic [DATA_W-1:0]        port_in_data,
    input  logic                     port_in_valid,
    output logic                     port_in_ready,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_count,
    input  logic                     clr_flags,
    output logic                     tx_overflow,
    output logic                     rx_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rxData;
    logic              r_rxFull;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;
    logic              r_txOverflow;
    logic              r_rxUnderflow;

    logic w_writeReq;
    logic w_readReq;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_capture;

    assign w_writeReq = io_enable & io_write_enable;
    assign w_readReq  = io_enable & ~io_write_enable;
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_pop      = (r_count != '0) & port_out_ready;
    // A write into a full FIFO still lands if the head leaves in the same cycle.
    assign w_push     = w_writeReq & (~w_full | w_pop);
    assign w_drop     = w_writeReq & ~w_push;
    assign w_capture  = port_in_valid & ~r_rxFull;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Capture and read-release never collide: capture needs the holder empty,
    // release needs it full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxData  <= '0;
            r_rxFull  <= 1'b0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_readReq;
            if (w_capture) begin
                r_rxData <= port_in_data;
                r_rxFull <= 1'b1;
            end else if (w_readReq && r_rxFull) begin
                r_rxFull <= 1'b0;
            end
            if (w_readReq) begin
                r_rdData <= r_rxFull ? r_rxData : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txOverflow  <= 1'b0;
            r_rxUnderflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_txOverflow <= 1'b1;
            end else if (clr_flags) begin
                r_txOverflow <= 1'b0;
            end
            if (w_readReq && !r_rxFull) begin
                r_rxUnderflow <= 1'b1;
            end else if (clr_flags) begin
                r_rxUnderflow <= 1'b0;
            end
        end
    end

    assign port_out_data  = r_mem[r_rdPtr];
    assign port_out_valid = (r_count != '0);
    assign tx_full        = w_full;
    assign tx_count       = r_count;
    assign port_in_ready  = ~r_rxFull;
    assign rd_data        = r_rdData;
    assign rd_valid       = r_rdValid;
    assign tx_overflow    = r_txOverflow;
    assign rx_underflow   = r_rxUnderflow;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: expected TX and read bytes go into queues
// that a negedge monitor drains whenever the DUT presents a transfer.
module tb_io_port_unit;

    logic       clk;
    logic       reset;
    logic       io_enable;
    logic       io_write_enable;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] port_out_data;
    logic       port_out_valid;
    logic       port_out_ready;
    logic [7:0] port_in_data;
    logic       port_in_valid;
    logic       port_in_ready;
    logic       tx_full;
    logic [2:0] tx_count;
    logic       clr_flags;
    logic       tx_overflow;
    logic       rx_underflow;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    io_port_unit #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .io_enable(io_enable), .io_write_enable(io_write_enable),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .port_out_data(port_out_data), .port_out_valid(port_out_valid),
        .port_out_ready(port_out_ready),
        .port_in_data(port_in_data), .port_in_valid(port_in_valid),
        .port_in_ready(port_in_ready),
        .tx_full(tx_full), .tx_count(tx_count), .clr_flags(clr_flags),
        .tx_overflow(tx_overflow), .rx_underflow(rx_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; strobes are dropped again right after the edge.
    task automatic applyStimulus(input logic en, input logic we, input logic [7:0] d,
                                 input logic rdy, input logic inV, input logic [7:0] inD,
                                 input logic clr);
        io_enable       = en;
        io_write_enable = we;
        wr_data         = d;
        port_out_ready  = rdy;
        port_in_valid   = inV;
        port_in_data    = inD;
        clr_flags       = clr;
        @(posedge clk);
        #1;
        io_enable     = 1'b0;
        port_in_valid = 1'b0;
        clr_flags     = 1'b0;
    endtask

    task automatic drainTx();
        int n;
        n = 0;
        port_out_ready = 1'b1;
        while (port_out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_timeout", {31'd0, port_out_valid}, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_count"}, tx_count, 0);
        checkOutput({tag, "_out_valid"}, port_out_valid, 0);
        checkOutput({tag, "_tx_full"}, tx_full, 0);
        checkOutput({tag, "_in_ready"}, port_in_ready, 1);
        checkOutput({tag, "_rd_valid"}, rd_valid, 0);
        checkOutput({tag, "_rd_data"}, rd_data, 0);
        checkOutput({tag, "_tx_ovf"}, tx_overflow, 0);
        checkOutput({tag, "_rx_unf"}, rx_underflow, 0);
    endtask

    // Monitor: every accepted TX byte and every read response is compared
    // against the head of its expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (port_out_valid && port_out_ready) begin
                if (txq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL tx_unexpected: got %0h, expected no transfer", port_out_data);
                end else begin
                    checkOutput("tx_data", port_out_data, txq.pop_front());
                end
            end
            if (rd_valid) begin
                if (rxq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL rd_unexpected: got %0h, expected no read", rd_data);
                end else begin
                    checkOutput("rd_data", rd_data, rxq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] fillBytes [4];
        fillBytes = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset = 1'b1;
        io_enable = 0; io_write_enable = 0; wr_data = 0;
        port_out_ready = 0; port_in_valid = 0; port_in_data = 0; clr_flags = 0;
        #3;
        checkResetValues("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] fill and drain / overflow");
        for (int i = 0; i < 4; i++) begin
            txq.push_back(fillBytes[i]);
            applyStimulus(1, 1, fillBytes[i], 0, 0, 8'h00, 0);
        end
        checkOutput("fill_count", tx_count, 4);
        checkOutput("fill_full", tx_full, 1);
        checkOutput("fill_head", port_out_data, 8'h11);

        applyStimulus(1, 1, 8'h55, 0, 0, 8'h00, 0);
        checkOutput("ovf_flag", tx_overflow, 1);
        checkOutput("ovf_count", tx_count, 4);
        checkOutput("ovf_head", port_out_data, 8'h11);

        txq.push_back(8'h66);
        applyStimulus(1, 1, 8'h66, 1, 0, 8'h00, 0);
        checkOutput("fullpop_count", tx_count, 4);
        drainTx();
        checkOutput("drain_txq_empty", txq.size(), 0);
        checkOutput("drain_count", tx_count, 0);

        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 1);
        checkOutput("ovf_cleared", tx_overflow, 0);

        $display("[TB] wrap-around streaming");
        for (int i = 0; i < 10; i++) begin
            txq.push_back(8'hB0 + 8'(i));
            applyStimulus(1, 1, 8'hB0 + 8'(i), 1, 0, 8'h00, 0);
            checkOutput("wrap_count", tx_count, 1);
        end
        drainTx();
        checkOutput("wrap_txq_empty", txq.size(), 0);

        $display("[TB] RX capture and read");
        port_out_ready = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 1, 8'hA5, 0);
        checkOutput("rx_ready_low", port_in_ready, 0);
        rxq.push_back(8'hA5);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkOutput("rx_ready_back", port_in_ready, 1);
        checkOutput("rd_valid_pulse", rd_valid, 1);
        checkOutput("rx_no_unf", rx_underflow, 0);
        @(posedge clk);
        #1;
        checkOutput("rd_valid_drop", rd_valid, 0);

        $display("[TB] underflow and sticky clear");
        rxq.push_back(8'h00);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkOutput("unf_set", rx_underflow, 1);
        rxq.push_back(8'h00);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("unf_set_wins", rx_underflow, 1);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("unf_cleared", rx_underflow, 0);

        rxq.push_back(8'h00);
        applyStimulus(1, 0, 8'h00, 0, 1, 8'h3C, 0);
        checkOutput("unf_capture_flag", rx_underflow, 1);
        checkOutput("unf_capture_held", port_in_ready, 0);
        rxq.push_back(8'h3C);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkOutput("unf_capture_freed", port_in_ready, 1);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1);

        $display("[TB] reset mid-traffic");
        txq.push_back(8'hC1);
        applyStimulus(1, 1, 8'hC1, 0, 0, 8'h00, 0);
        txq.push_back(8'hC2);
        applyStimulus(1, 1, 8'hC2, 0, 1, 8'h5A, 0);
        txq.push_back(8'hC3);
        applyStimulus(1, 1, 8'hC3, 0, 0, 8'h00, 0);
        checkOutput("pre_reset_count", tx_count, 3);
        checkOutput("pre_reset_rxfull", port_in_ready, 0);
        #2;
        reset = 1'b1;
        txq.delete();
        rxq.delete();
        #1;
        checkResetValues("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", port_in_ready, 1);
        checkOutput("post_reset_out_valid", port_out_valid, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_txq_empty", txq.size(), 0);
        checkOutput("final_rxq_empty", rxq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
